// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative MUL sequencer.
// Optional feature macro: MUL_EARLY_OUT_EN.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_STEP  = 1;

    // Decode values that drive mul_start.
    localparam logic [5:0] MUL_OPCODE = 6'b011100;
    localparam logic [5:0] MUL_FUNCT  = 6'b000010;

    function automatic int mul_latency(input int width, input int step);
        return width / step + 1;
    endfunction

endpackage

// File: rtl/mul_step_add.sv
// Combinational partial-product adder: acc + ((mag_a * bits) << shamt).
// Used once per RUN cycle by mul_seq_ctrl.
module mul_step_add
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int STEP  = MUL_STEP,
    parameter int SW    = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag_a,
    input  logic [STEP-1:0]    bits,
    input  logic [SW-1:0]      shamt,
    output logic [2*WIDTH-1:0] acc_nxt
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] pp;

    always_comb begin
        pp      = {{WIDTH{1'b0}}, mag_a} * {{(PW - STEP){1'b0}}, bits};
        acc_nxt = acc + (pp << shamt);
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add MUL sequencer that stalls the CPU until the product is ready.
// Define MUL_EARLY_OUT_EN to finish as soon as the multiplier runs out.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int STEP  = MUL_STEP
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mul_start,
    input  logic             mul_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             mul_busy,
    output logic             cpu_stall,
    output logic             mul_end,
    output logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] mul_hi
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(2 * WIDTH);
    localparam int PW = 2 * WIDTH;

    mul_state_e       state;
    logic [CW-1:0]    counter;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mplr;
    logic             neg;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [CW-1:0]    done_cnt;
    logic [SW-1:0]    shamt;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    prod;
    logic             last;

    always_comb begin
        a_abs    = (mul_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_abs    = (mul_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        done_cnt = CW'(N) - counter;
        shamt    = SW'(done_cnt) * SW'(STEP);
        prod     = neg ? -acc_nxt : acc_nxt;
    end

`ifdef MUL_EARLY_OUT_EN
    assign last = (counter == CW'(1)) || ((mplr >> STEP) == '0);
`else
    assign last = (counter == CW'(1));
`endif

    mul_step_add #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_step (
        .acc     (acc),
        .mag_a   (mag_a),
        .bits    (mplr[STEP-1:0]),
        .shamt   (shamt),
        .acc_nxt (acc_nxt)
    );

    // Issue cycle stalls combinationally; RUN stalls from state alone.
    assign cpu_stall = resetn &
                       (((state == IDLE) & mul_start) | (state == RUN));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            counter  <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mplr     <= '0;
            neg      <= 1'b0;
            mul_busy <= 1'b0;
            mul_end  <= 1'b0;
            mul_lo   <= '0;
            mul_hi   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mul_end <= 1'b0;
                    if (mul_start) begin
                        state    <= RUN;
                        mag_a    <= a_abs;
                        mplr     <= b_abs;
                        neg      <= mul_signed &
                                    (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        acc      <= '0;
                        counter  <= CW'(N);
                        mul_busy <= 1'b1;
                    end
                end
                RUN: begin
                    acc     <= acc_nxt;
                    mplr    <= mplr >> STEP;
                    counter <= counter - CW'(1);
                    if (last) begin
                        state   <= DONE;
                        mul_end <= 1'b1;
                        mul_hi  <= prod[PW-1:WIDTH];
                        mul_lo  <= prod[WIDTH-1:0];
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mul_end  <= 1'b0;
                    mul_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mul_end  <= 1'b0;
                    mul_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl (WIDTH=32, STEP=1).
// Honors MUL_EARLY_OUT_EN for the expected early-out latencies.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        resetn;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        mul_busy;
    logic        cpu_stall;
    logic        mul_end;
    logic [31:0] mul_lo;
    logic [31:0] mul_hi;

    int checks   = 0;
    int failures = 0;

    mul_seq_ctrl #(
        .WIDTH (32),
        .STEP  (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .mul_busy   (mul_busy),
        .cpu_stall  (cpu_stall),
        .mul_end    (mul_end),
        .mul_lo     (mul_lo),
        .mul_hi     (mul_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one MUL and follow it until one cycle past its end pulse.
    task automatic run_mul(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic sgn,
                           input bit inject, input logic [63:0] exp,
                           input int exp_lat);
        int          lat;
        int          ends;
        int          stalls;
        logic        stall_end;
        logic        busy_end;
        logic [63:0] res;
        lat       = 0;
        ends      = 0;
        stalls    = 1;
        stall_end = 1'bx;
        busy_end  = 1'bx;
        res       = 'x;
        @(negedge clk);
        operand_a  = a;
        operand_b  = b;
        mul_signed = sgn;
        mul_start  = 1'b1;
        #1;
        chk({tag, ".issue_stall"}, 64'(cpu_stall), 64'd1);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        if (cpu_stall) stalls++;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (inject && i == 5) begin
                operand_a  = 32'd2;
                operand_b  = 32'd2;
                mul_start  = 1'b1;
            end
            if (inject && i == 6) mul_start = 1'b0;
            if (mul_end) begin
                ends++;
                if (lat == 0) begin
                    lat       = i + 1;
                    res       = {mul_hi, mul_lo};
                    stall_end = cpu_stall;
                    busy_end  = mul_busy;
                end
            end
            if (cpu_stall) stalls++;
            if (lat != 0 && i >= lat) break;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".product"}, res, exp);
        chk({tag, ".end_count"}, 64'(ends), 64'd1);
        chk({tag, ".done_stall"}, 64'(stall_end), 64'd0);
        chk({tag, ".done_busy"}, 64'(busy_end), 64'd1);
        chk({tag, ".stall_cycles"}, 64'(stalls), 64'(exp_lat));
        chk({tag, ".idle_busy"}, 64'(mul_busy), 64'd0);
    endtask

    initial begin
        int ends;
        resetn     = 1'b0;
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        operand_a  = '0;
        operand_b  = '0;

        #12;
        chk("rst.busy", 64'(mul_busy), 64'd0);
        chk("rst.stall", 64'(cpu_stall), 64'd0);
        chk("rst.end", 64'(mul_end), 64'd0);
        chk("rst.result", {mul_hi, mul_lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_mul("u3x3", 32'd3, 32'd3, 1'b0, 1'b0, 64'd9, 33);
        run_mul("u8x3", 32'd8, 32'd3, 1'b0, 1'b0, 64'd24, 33);
        run_mul("u15x5", 32'd15, 32'd5, 1'b0, 1'b0, 64'd75, 33);

        run_mul("s_m5x7", 32'hFFFF_FFFB, 32'd7, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFDD, 33);
        run_mul("u_m5x7", 32'hFFFF_FFFB, 32'd7, 1'b0, 1'b0,
                64'h0000_0006_FFFF_FFDD, 33);
        run_mul("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0,
                64'h4000_0000_0000_0000, 33);
        run_mul("s_min_x1", 32'h8000_0000, 32'd1, 1'b1, 1'b0,
                64'hFFFF_FFFF_8000_0000, 33);

        run_mul("inject", 32'd9, 32'd11, 1'b0, 1'b1, 64'd99, 33);

        @(negedge clk);
        operand_a  = 32'd123;
        operand_b  = 32'd456;
        mul_signed = 1'b0;
        mul_start  = 1'b1;
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("midrst.pre_stall", 64'(cpu_stall), 64'd1);
        resetn = 1'b0;
        #1;
        chk("midrst.busy", 64'(mul_busy), 64'd0);
        chk("midrst.stall", 64'(cpu_stall), 64'd0);
        chk("midrst.end", 64'(mul_end), 64'd0);
        chk("midrst.result", {mul_hi, mul_lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        ends = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mul_end) ends++;
        end
        chk("midrst.no_end", 64'(ends), 64'd0);
        run_mul("post_rst_6x7", 32'd6, 32'd7, 1'b0, 1'b0, 64'd42, 33);

`ifdef MUL_EARLY_OUT_EN
        run_mul("eo_2x3", 32'd2, 32'd3, 1'b0, 1'b0, 64'd6, 3);
        run_mul("eo_5x0", 32'd5, 32'd0, 1'b0, 1'b0, 64'd0, 2);
`else
        run_mul("eo_2x3", 32'd2, 32'd3, 1'b0, 1'b0, 64'd6, 33);
        run_mul("eo_5x0", 32'd5, 32'd0, 1'b0, 1'b0, 64'd0, 33);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
